// File: rtl/pipe_skid_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline stage registers of the RISC-V core.
//   - Field widths of the architectural payloads (XLEN, REG_W, RSRC_W).
//   - MEMWB_W and memwb_t: the packed MEM/WB payload carried by a
//     pipe_skid_stage with WIDTH = MEMWB_W.
//   - skid_state_e: occupancy state of a pipe_skid_stage, and state_occ(),
//     which maps a state to its entry count.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_W  = 5;
  localparam int RSRC_W = 2;
  localparam int OCC_W  = 2;

  // regWrite + resultSrc + rd + four XLEN words = 136 bits
  localparam int MEMWB_W = 1 + RSRC_W + REG_W + 4 * XLEN;

  typedef struct packed {
    logic              regWrite;
    logic [RSRC_W-1:0] resultSrc;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   aluResult;
    logic [XLEN-1:0]   readData;
    logic [XLEN-1:0]   pcPlus4;
    logic [XLEN-1:0]   extImm;
  } memwb_t;

  // The state is the occupancy itself: skid is only ever valid on top of main.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [OCC_W-1:0] state_occ(input skid_state_e s);
    logic [OCC_W-1:0] n;
    n = 2'd0;
    case (s)
      ST_ONE:  n = 2'd1;
      ST_FULL: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage_if
//   Handshake bundle around one pipe_skid_stage.
//   Signals:
//     flush               synchronous kill of all held entries
//     in_valid/in_data    upstream beat offered to the stage
//     in_ready            stage can accept (registered in the stage)
//     out_valid/out_data  beat presented downstream from the main slot
//     out_ready           downstream accepts
//     occ                 number of entries held, 0..2
//   Modports:
//     slave  - the stage itself
//     master - the surrounding producer/consumer (pipeline or testbench)
// -----------------------------------------------------------------------------
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occ;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occ
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ
  );

endinterface

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//   Pipeline stage register with a valid/ready handshake and a one-entry skid
//   buffer. The main slot drives the downstream side; the skid slot catches
//   the beat that arrives while main is stalled, which lets in_ready come
//   straight from a flop and still sustain one beat per cycle.
//   Parameters:
//     WIDTH          payload width (MEM/WB uses pipe_pkg::MEMWB_W)
//     CLEAR_ON_FLUSH 1: flush zeroes both data registers; 0: data retained
//   Ports:
//     clk  clock, rising edge
//     rst  synchronous active-high reset
//     bus  pipe_skid_stage_if.slave (flush, in_*, out_*, occ)
//   All outputs are registered: no combinational path from out_ready to
//   in_ready, nor from in_* to out_*.
// -----------------------------------------------------------------------------
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  pipe_skid_stage_if.slave    bus
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [OCC_W-1:0] occ_q;

  logic accept;
  logic drain;

  // Next-state and data-path selection.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    accept = bus.in_valid & in_ready_q;
    drain  = out_valid_q & bus.out_ready;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = bus.in_data;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_d = bus.in_data;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = bus.in_data;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so no accept can coincide with the drain.
        if (drain) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A beat accepted in the flush cycle is dropped along with the rest.
    if (bus.flush) begin
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end
  end

  // State, data and registered handshake outputs. The outputs are derived
  // from state_d so they are plain flops aligned with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_FULL);
      occ_q       <= state_occ(state_d);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.occ       = occ_q;

endmodule
